// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcode map, ALU encodings, field positions and decode helper for id_stage_pipe
package id_pkg;

    // Instruction field bit positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 5;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_SUBI = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_LDI  = 5'b01100;
    localparam logic [4:0] OP_LDD  = 5'b01101;
    localparam logic [4:0] OP_STD  = 5'b01110;
    localparam logic [4:0] OP_ADD  = 5'b10000;
    localparam logic [4:0] OP_SUB  = 5'b10001;
    localparam logic [4:0] OP_AND  = 5'b10010;
    localparam logic [4:0] OP_OR   = 5'b10011;
    localparam logic [4:0] OP_EOR  = 5'b10110;
    localparam logic [4:0] OP_NOT  = 5'b11100;
    localparam logic [4:0] OP_SHL  = 5'b11101;
    localparam logic [4:0] OP_SHR  = 5'b11110;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOT   = 4'd5;
    localparam logic [3:0] ALU_SHL   = 4'd6;
    localparam logic [3:0] ALU_SHR   = 4'd7;
    localparam logic [3:0] ALU_PASSB = 4'd8;

    typedef struct packed {
        logic       regwrite;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       illegal;
        logic       reads_rd;   // instruction consumes the rd register as a source
        logic       reads_rs;
        logic [3:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [4:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OP_LDI: begin
                c.regwrite = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_PASSB;
            end
            OP_LDD: begin
                c.regwrite = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1;
            end
            OP_STD: begin
                c.mem_write = 1'b1; c.alu_src = 1'b1; c.reads_rd = 1'b1;
            end
            // Immediate and register ALU groups share the low two opcode bits with the ALU code
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                c.regwrite = 1'b1; c.alu_src = 1'b1; c.reads_rd = 1'b1;
                c.alu_op = {2'b00, opc[1:0]};
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                c.regwrite = 1'b1; c.reads_rd = 1'b1; c.reads_rs = 1'b1;
                c.alu_op = {2'b00, opc[1:0]};
            end
            OP_EOR: begin
                c.regwrite = 1'b1; c.reads_rd = 1'b1; c.reads_rs = 1'b1; c.alu_op = ALU_XOR;
            end
            OP_NOT: begin c.regwrite = 1'b1; c.reads_rd = 1'b1; c.alu_op = ALU_NOT; end
            OP_SHL: begin c.regwrite = 1'b1; c.reads_rd = 1'b1; c.alu_op = ALU_SHL; end
            OP_SHR: begin c.regwrite = 1'b1; c.reads_rd = 1'b1; c.alu_op = ALU_SHR; end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - NREGS x DATA_W register file, one write port, two bypassed read ports
// Ports: clk, rst (async active-low), we/waddr/wdata write port,
//        raddr_a/rdata_a and raddr_b/rdata_b combinational read ports.
module id_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    import id_pkg::*;

    // Address bits above log2(NREGS) are ignored
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     wa, ra, rb;

    assign wa = waddr[AW-1:0];
    assign ra = raddr_a[AW-1:0];
    assign rb = raddr_b[AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (int'(wa) < NREGS)) begin
            regs[wa] <= wdata;
        end
    end

    // Same-cycle write-back is forwarded so the reader sees the value being written
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (we && wa == ra)          rdata_a = wdata;
        else if (int'(ra) < NREGS)   rdata_a = regs[ra];
        if (we && wa == rb)          rdata_b = wdata;
        else if (int'(rb) < NREGS)   rdata_b = regs[rb];
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - pipelined decode stage: decode, bypassed regfile read, load-use stall, output slot
// Ports: clk, rst (async active-low); in_valid/in_ready/instruction_input from IF;
//        flush; regwrite/write_addr/write_data write-back; ex_load_pending/ex_load_rd;
//        out_valid/out_ready plus registered decoded bundle to EX; stall_cnt.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instruction_input,
    input  logic              flush,
    input  logic              regwrite,
    input  logic [2:0]        write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              ex_load_pending,
    input  logic [2:0]        ex_load_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              regwrite_out,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic [3:0]        alu_op,
    output logic              illegal,
    output logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] imm,
    output logic [15:0]       instruction_output,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [2:0]        rd_f, rs_f;
    ctrl_t             dec;
    logic [DATA_W-1:0] rd_val, rs_val;
    logic              hit_rd, hit_rs, stall, xfer;

    assign rd_f = instruction_input[RD_MSB:RD_LSB];
    assign rs_f = instruction_input[RS_MSB:RS_LSB];
    assign dec  = decode(instruction_input[OPC_MSB:OPC_LSB]);

    id_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (regwrite),
        .waddr   (write_addr),
        .wdata   (write_data),
        .raddr_a (rd_f),
        .rdata_a (rd_val),
        .raddr_b (rs_f),
        .rdata_b (rs_val)
    );

    // A source is unsafe if the load sitting in our output slot or one further down
    // has not yet produced its value
    assign hit_rd = (out_valid && mem_to_reg && rd_addr == rd_f) ||
                    (ex_load_pending && ex_load_rd == rd_f);
    assign hit_rs = (out_valid && mem_to_reg && rd_addr == rs_f) ||
                    (ex_load_pending && ex_load_rd == rs_f);
    assign stall  = in_valid && ((dec.reads_rd && hit_rd) || (dec.reads_rs && hit_rs));

    assign in_ready = (!out_valid || out_ready) && !stall && !flush;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid          <= 1'b0;
            regwrite_out       <= 1'b0;
            mem_read           <= 1'b0;
            mem_write          <= 1'b0;
            mem_to_reg         <= 1'b0;
            alu_src            <= 1'b0;
            alu_op             <= '0;
            illegal            <= 1'b0;
            rd_addr            <= '0;
            rd_data            <= '0;
            rs_data            <= '0;
            imm                <= '0;
            instruction_output <= '0;
            stall_cnt          <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (xfer) begin
                out_valid          <= 1'b1;
                regwrite_out       <= dec.regwrite;
                mem_read           <= dec.mem_read;
                mem_write          <= dec.mem_write;
                mem_to_reg         <= dec.mem_to_reg;
                alu_src            <= dec.alu_src;
                alu_op             <= dec.alu_op;
                illegal            <= dec.illegal;
                rd_addr            <= rd_f;
                rd_data            <= rd_val;
                rs_data            <= rs_val;
                imm                <= DATA_W'(instruction_input[IMM_MSB:IMM_LSB]);
                instruction_output <= instruction_input;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (stall && !flush && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, regwrite, ex_load_pending, out_valid, out_ready;
    logic [15:0] instruction_input, instruction_output;
    logic [2:0]  write_addr, ex_load_rd, rd_addr;
    logic [7:0]  write_data, rd_data, rs_data, imm;
    logic        regwrite_out, mem_read, mem_write, mem_to_reg, alu_src, illegal;
    logic [3:0]  alu_op;
    logic [15:0] stall_cnt;

    logic        p_in_valid, p_in_ready, p_ex_load_pending, p_out_valid, p_out_ready;
    logic [15:0] p_instr, p_instruction_output, p_rd_data, p_rs_data, p_imm;
    logic [2:0]  p_ex_load_rd, p_rd_addr;
    logic        p_regwrite_out, p_mem_read, p_mem_write, p_mem_to_reg, p_alu_src, p_illegal;
    logic [3:0]  p_alu_op;
    logic [1:0]  p_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction_input(instruction_input), .flush(flush), .regwrite(regwrite),
        .write_addr(write_addr), .write_data(write_data), .ex_load_pending(ex_load_pending),
        .ex_load_rd(ex_load_rd), .out_valid(out_valid), .out_ready(out_ready),
        .regwrite_out(regwrite_out), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal),
        .rd_addr(rd_addr), .rd_data(rd_data), .rs_data(rs_data), .imm(imm),
        .instruction_output(instruction_output), .stall_cnt(stall_cnt)
    );

    id_stage_pipe #(.DATA_W(16), .NREGS(8), .CNT_W(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .instruction_input(p_instr), .flush(1'b0), .regwrite(1'b0),
        .write_addr(3'd0), .write_data(16'h0000), .ex_load_pending(p_ex_load_pending),
        .ex_load_rd(p_ex_load_rd), .out_valid(p_out_valid), .out_ready(p_out_ready),
        .regwrite_out(p_regwrite_out), .mem_read(p_mem_read), .mem_write(p_mem_write),
        .mem_to_reg(p_mem_to_reg), .alu_src(p_alu_src), .alu_op(p_alu_op), .illegal(p_illegal),
        .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rs_data(p_rs_data), .imm(p_imm),
        .instruction_output(p_instruction_output), .stall_cnt(p_stall_cnt)
    );

    // ctrl = {regwrite, mem_read, mem_write, mem_to_reg, alu_src, illegal, alu_op[3:0]}
    typedef struct {
        logic [15:0] instr;
        logic        wb;
        logic [2:0]  wa;
        logic [7:0]  wd;
        logic [9:0]  ctrl;
        logic [7:0]  rd;
        logic [7:0]  rs;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{16'h8220, 1'b0, 3'd0, 8'h00, 10'b100000_0000, 8'h01, 8'h33}; // ADD r2,r1
        vecs[1] = '{16'h8A20, 1'b1, 3'd1, 8'h44, 10'b100000_0001, 8'h01, 8'h44}; // SUB + bypass
        vecs[2] = '{16'hF800, 1'b0, 3'd0, 8'h00, 10'b000001_0000, 8'h00, 8'h00}; // illegal 11111
        vecs[3] = '{16'h7101, 1'b0, 3'd0, 8'h00, 10'b001010_0000, 8'h44, 8'h00}; // STD r1
        vecs[4] = '{16'h63FF, 1'b0, 3'd0, 8'h00, 10'b100010_1000, 8'h00, 8'h00}; // LDI r3,0xFF
        vecs[5] = '{16'hB140, 1'b0, 3'd0, 8'h00, 10'b100000_0100, 8'h44, 8'h01}; // EOR r1,r2
        vecs[6] = '{16'hEA00, 1'b0, 3'd0, 8'h00, 10'b100000_0110, 8'h01, 8'h00}; // SHL r2
        vecs[7] = '{16'h590F, 1'b0, 3'd0, 8'h00, 10'b100010_0011, 8'h44, 8'h00}; // ORI r1
        vecs[8] = '{16'h6C02, 1'b0, 3'd0, 8'h00, 10'b110110_0000, 8'h00, 8'h00}; // LDD r4

        rst = 1'b0; in_valid = 0; instruction_input = 0; flush = 0; regwrite = 0;
        write_addr = 0; write_data = 0; ex_load_pending = 0; ex_load_rd = 0; out_ready = 0;
        p_in_valid = 0; p_instr = 0; p_ex_load_pending = 0; p_ex_load_rd = 0; p_out_ready = 0;

        // Reset state
        step();
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset stall_cnt", 32'(stall_cnt), 0);
        chk("reset bundle", {rd_data, rs_data, imm, 8'(alu_op)}, 0);
        chk("reset instr_out", 32'(instruction_output), 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Fill X1=0x33, X2=0x01 through write-back
        regwrite = 1; write_addr = 3'd1; write_data = 8'h33;
        step();
        write_addr = 3'd2; write_data = 8'h01;
        step();
        regwrite = 0;

        // Decode table: one transfer, check, then one bubble cycle
        for (int i = 0; i < 9; i++) begin
            in_valid = 1; instruction_input = vecs[i].instr; out_ready = 1;
            regwrite = vecs[i].wb; write_addr = vecs[i].wa; write_data = vecs[i].wd;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 1);
            step();
            in_valid = 0; regwrite = 0;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d ctrl", i),
                32'({regwrite_out, mem_read, mem_write, mem_to_reg, alu_src, illegal, alu_op}),
                32'(vecs[i].ctrl));
            chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
            chk($sformatf("v%0d rs_data", i), 32'(rs_data), 32'(vecs[i].rs));
            chk($sformatf("v%0d imm", i), 32'(imm), 32'(vecs[i].instr[7:0]));
            chk($sformatf("v%0d rd_addr", i), 32'(rd_addr), 32'(vecs[i].instr[10:8]));
            chk($sformatf("v%0d instr_out", i), 32'(instruction_output), 32'(vecs[i].instr));
            step();
            chk($sformatf("v%0d bubble", i), 32'(out_valid), 0);
        end

        // Load-use: LDD r4 held under backpressure, then ADDI r4 stalls
        in_valid = 1; instruction_input = 16'h6C02; out_ready = 0;
        step();
        chk("ldd accepted", 32'({out_valid, mem_to_reg}), 32'b11);
        instruction_input = 16'h4401;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("stall in_ready c%0d", c), 32'(in_ready), 0);
            step();
            chk($sformatf("stall_cnt c%0d", c), 32'(stall_cnt), 32'(c));
        end
        out_ready = 1;
        #1;
        chk("stall in_ready w/ out_ready", 32'(in_ready), 0);
        step();
        chk("stall bubble out_valid", 32'(out_valid), 0);
        chk("stall_cnt after bubble", 32'(stall_cnt), 4);
        chk("stall cleared in_ready", 32'(in_ready), 1);
        step();
        chk("addi accepted", 32'(out_valid), 1);
        chk("addi instr_out", 32'(instruction_output), 32'h4401);
        chk("addi imm", 32'(imm), 1);
        chk("addi ctrl", 32'({regwrite_out, mem_read, mem_to_reg, alu_src, alu_op}), 32'b1001_0000);
        chk("stall_cnt stable", 32'(stall_cnt), 4);

        // Backpressure: outputs hold, in_ready low
        out_ready = 0; instruction_input = 16'h8220;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp in_ready c%0d", c), 32'(in_ready), 0);
            step();
            chk($sformatf("bp hold c%0d", c), {out_valid, 7'd0, imm, instruction_output}, {1'b1, 7'd0, 8'h01, 16'h4401});
        end
        flush = 1;
        #1;
        chk("flush in_ready", 32'(in_ready), 0);
        step();
        flush = 0; in_valid = 0;
        chk("flush out_valid", 32'(out_valid), 0);
        chk("flush not captured", 32'(instruction_output), 32'h4401);
        chk("flush no stall count", 32'(stall_cnt), 4);

        // Flush overrides a valid, unstalled input
        in_valid = 1; out_ready = 1; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("flush vs in_valid", 32'({out_valid, instruction_output}), 32'h4401);

        // Reset mid-transfer discards the held bundle and clears the regfile
        in_valid = 1; instruction_input = 16'h63FF; out_ready = 0;
        step();
        chk("pre-reset valid", 32'(out_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("midreset out_valid", 32'(out_valid), 0);
        chk("midreset bundle", {imm, 8'(alu_op), instruction_output}, 0);
        chk("midreset stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        instruction_input = 16'h8220; out_ready = 1;
        step();
        in_valid = 0;
        chk("regfile cleared", 32'({out_valid, rd_data, rs_data}), 32'h1_0000);

        // Wide-data / narrow-counter instance
        p_in_valid = 1; p_instr = 16'h63FF; p_out_ready = 0;
        step();
        chk("p ldi imm", 32'(p_imm), 32'h00FF);
        chk("p ldi ctrl", 32'({p_out_valid, p_regwrite_out, p_alu_src, p_alu_op}), 32'b111_1000);
        p_instr = 16'h4301; p_ex_load_pending = 1; p_ex_load_rd = 3'd3;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("p stall_cnt c%0d", c), 32'(p_stall_cnt), (c > 3) ? 32'd3 : 32'(c));
        end
        chk("p in_ready", 32'(p_in_ready), 0);
        chk("p hold imm", 32'(p_imm), 32'h00FF);
        p_in_valid = 0; p_ex_load_pending = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor of the single-cycle `id` decode stage for the 16-bit-instruction RISC core.
- Decodes one instruction per transfer and reads the register file with write-back bypass.
- Detects load-use hazards and stalls on them.
- Registers the decoded bundle into one pipeline slot with valid/ready handshakes on both sides.
- Sits between IF and EX. Adds flush, illegal-opcode flagging and a stall counter.

Parameters:
- DATA_W, 8: register/data width. Immediate is zero-extended from 8 bits to DATA_W.
- NREGS, 8: register count. Must be ≤ 8, because the fields are 3 bits. Register-address bits ≥ log2(NREGS) are ignored.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction_input is valid
- in_ready  out  1  stage accepts instruction this cycle
- instruction_input  in  16  [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] k/A
- flush  in  1  kill held and incoming instruction
- regwrite  in  1  write-back enable
- write_addr  in  3  write-back register
- write_data  in  DATA_W  write-back data
- ex_load_pending  in  1  a load downstream of EX has not yet written back
- ex_load_rd  in  3  destination of that load
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EX accepts bundle
- regwrite_out, mem_read, mem_write, mem_to_reg, alu_src  out  1 each  control bits
- alu_op  out  4  ALU function (package encoding)
- illegal  out  1  opcode not in map
- rd_addr  out  3  destination field
- rd_data, rs_data  out  DATA_W  operands after bypass
- imm  out  DATA_W  zero-extended k/A
- instruction_output  out  16  registered instruction
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers and all outputs go to 0; out_valid=0; stall_cnt=0.
  - Reset mid-transfer discards the held bundle.
- Decode map (opcode: controls):
  - LDI 01100: regwrite, alu_src; ALU=PASSB.
  - LDD 01101: regwrite, mem_read, mem_to_reg, alu_src.
  - STD 01110: mem_write, alu_src; reads [10:8].
  - ADDI/SUBI/ANDI/ORI 01000–01011: regwrite, alu_src; reads rd.
  - ADD/SUB/AND/OR 10000–10011 and EOR 10110: regwrite; read rd, rs.
  - NOT/SHL/SHR 11100–11110: regwrite; read rd.
  - Any other opcode: illegal=1, all control bits 0, still passed downstream.
- Register read:
  - Combinational from the regfile, indexed by rd/rs.
  - If regwrite and write_addr matches, write_data is returned (same-cycle bypass).
  - The regfile is written at the rising edge when regwrite=1.
  - R0 is an ordinary register.
- Hazard detect: stall=1 when in_valid and the instruction reads register R, and either:
  - out_valid && mem_to_reg && rd_addr==R, or
  - ex_load_pending && ex_load_rd==R.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !stall && !flush.
  - Transfer in when in_valid && in_ready; the bundle is registered; latency 1 cycle.
  - If out_ready && out_valid and no transfer in, out_valid clears next cycle (bubble).
  - While out_valid && !out_ready, every output holds stable.
- Flush:
  - At the next edge out_valid=0; no transfer in that cycle.
  - Flush overrides stall and in_valid.
- stall_cnt:
  - +1 on each cycle with in_valid && stall && !flush.
  - Saturates at 2^CNT_W−1; no wrap.
- Simultaneous write-back and read of the same register in the accept cycle: the captured operand is write_data.

Decomposition:
- Package id_pkg holds:
  - opcode localparams (OP_LDI … OP_SHR);
  - alu_op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOT 5, SHL 6, SHR 7, PASSB 8;
  - field bit positions.
- Sub-module id_regfile: NREGS×DATA_W array with asynchronous active-low reset, one write port and two bypassed read ports.
- The top level holds the decoder, hazard logic, pipeline register and counter.

Test Plan:
- Reset then fill registers:
  - Stimulus: rst low then high; write X1=0x33 and X2=0x01 through the write-back port; then present ADD 10000_010_001_00000 with out_ready=1.
  - Required: next cycle rd_data=0x01, rs_data=0x33, regwrite_out=1, alu_op=0, alu_src=0.
- Bypass:
  - Stimulus: present SUB rd=2 rs=1 in the same cycle as regwrite=1, write_addr=1, write_data=0x44.
  - Required: rs_data=0x44 in the registered bundle.
- Load-use stall:
  - Stimulus: accept LDD 01101_100_00000010 with out_ready=0; then present ADDI 01000_100_00000001.
  - Required: in_ready=0 and stall_cnt increments each cycle.
  - Stimulus: raise out_ready.
  - Required: out_valid drops (bubble) and the ADDI is accepted the following cycle; imm=0x01.
- Backpressure and flush:
  - Stimulus: hold out_ready=0 for 3 cycles.
  - Required: outputs stable and in_ready=0.
  - Stimulus: assert flush.
  - Required: out_valid=0 next cycle; the flushed input is not captured.
- Illegal and STD:
  - Stimulus: present opcode 11111.
  - Required: illegal=1, all control 0.
  - Stimulus: present STD 01110_001_00000001.
  - Required: mem_write=1, alu_src=1, rd_data=X1, regwrite_out=0.
- Parameter sweep:
  - Stimulus: DATA_W=16, CNT_W=2; force 5 stall cycles.
  - Required: stall_cnt=3 (saturated); LDI k=0xFF gives imm=0x00FF.
